// File: rtl/ysyx_23060332_idu_pkg.sv
// rtl/ysyx_23060332_idu_pkg.sv - shared opcode, func3 and ALU-op definitions for the decode stage
package ysyx_23060332_idu_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_BGE     = 3'b101;
    localparam logic [2:0] F3_BLTU    = 3'b110;
    localparam logic [2:0] F3_BGEU    = 3'b111;
    localparam logic [2:0] F3_LD      = 3'b011;
    localparam logic [2:0] F3_LWU     = 3'b110;
    localparam logic [2:0] F3_SD      = 3'b011;

    localparam logic [31:0] INST_NOP    = 32'h0000_0013;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU
    } alu_op_e;

    // alt selects SUB/SRA; callers must only raise it where the encoding allows
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD_SUB: alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     alu_from_f3 = ALU_SLL;
            F3_SLT:     alu_from_f3 = ALU_SLT;
            F3_SLTU:    alu_from_f3 = ALU_SLTU;
            F3_XOR:     alu_from_f3 = ALU_XOR;
            F3_SRL_SRA: alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      alu_from_f3 = ALU_OR;
            default:    alu_from_f3 = ALU_AND;
        endcase
    endfunction

    function automatic alu_op_e branch_alu_op(input logic [2:0] f3);
        case (f3)
            F3_BEQ:  branch_alu_op = ALU_EQ;
            F3_BNE:  branch_alu_op = ALU_NE;
            F3_BLT:  branch_alu_op = ALU_LT;
            F3_BGE:  branch_alu_op = ALU_GE;
            F3_BLTU: branch_alu_op = ALU_LTU;
            F3_BGEU: branch_alu_op = ALU_GEU;
            default: branch_alu_op = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060332_imm_gen.sv
// rtl/ysyx_23060332_imm_gen.sv - sign-extended I/S/B/U/J immediate generator
module ysyx_23060332_imm_gen #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] imm_s,
    output logic [XLEN-1:0] imm_b,
    output logic [XLEN-1:0] imm_u,
    output logic [XLEN-1:0] imm_j
);

    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

endmodule

// File: rtl/ysyx_23060332_idu_stage.sv
// rtl/ysyx_23060332_idu_stage.sv - RV32I/RV64I decode stage with one registered output slot
// Optional: YSYX_23060332_IDU_ILLEGAL_CHK_EN registers the illegal flag
module ysyx_23060332_idu_stage
    import ysyx_23060332_idu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RF_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_inst,
    input  logic [XLEN-1:0]      in_pc,
    output logic [RF_ADDR_W-1:0] raddr1,
    output logic [RF_ADDR_W-1:0] raddr2,
    input  logic [XLEN-1:0]      rdata1,
    input  logic [XLEN-1:0]      rdata2,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      op1,
    output logic [XLEN-1:0]      op2,
    output logic [XLEN-1:0]      op1_jump,
    output logic [XLEN-1:0]      op2_jump,
    output logic [XLEN-1:0]      store_data,
    output alu_op_e              alu_op,
    output logic                 reg_wen,
    output logic [RF_ADDR_W-1:0] waddr,
    output logic                 is_jump,
    output logic                 is_branch,
    output logic                 mem_ren,
    output logic                 mem_wen,
    output logic                 is_ebreak,
    output logic                 illegal,
    output logic [2:0]           mem_size,
    output logic [31:0]          inst_o,
    output logic [XLEN-1:0]      pc_o
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd, rs1, rs2;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc = in_inst[6:0];
    assign f3  = in_inst[14:12];
    assign f7  = in_inst[31:25];
    assign rd  = in_inst[11:7];
    assign rs1 = in_inst[19:15];
    assign rs2 = in_inst[24:20];

    ysyx_23060332_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst  (in_inst),
        .imm_i (imm_i),
        .imm_s (imm_s),
        .imm_b (imm_b),
        .imm_u (imm_u),
        .imm_j (imm_j)
    );

    logic use_rs1, use_rs2, use_rd, bad;
    logic [XLEN-1:0] d_op1, d_op2, d_j1, d_j2, d_sd;
    alu_op_e d_alu;
    logic d_wen, d_jump, d_branch, d_ren, d_mwen, d_ebreak;
    logic [2:0] d_size;
    logic [RF_ADDR_W-1:0] d_waddr;

    always_comb begin
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        use_rd   = 1'b0;
        bad      = 1'b0;
        d_op1    = '0;
        d_op2    = '0;
        d_j1     = '0;
        d_j2     = '0;
        d_sd     = '0;
        d_alu    = ALU_ADD;
        d_jump   = 1'b0;
        d_branch = 1'b0;
        d_ren    = 1'b0;
        d_mwen   = 1'b0;
        d_ebreak = 1'b0;
        d_size   = 3'b0;
        case (opc)
            OPC_LUI: begin
                use_rd = 1'b1;
                d_op1  = imm_u;
            end
            OPC_AUIPC: begin
                use_rd = 1'b1;
                d_op1  = in_pc;
                d_op2  = imm_u;
            end
            OPC_JAL, OPC_JALR: begin
                use_rd  = 1'b1;
                use_rs1 = (opc == OPC_JALR);
                d_jump  = 1'b1;
                d_op1   = in_pc;
                d_op2   = XLEN'(4);
                d_j1    = (opc == OPC_JALR) ? rdata1 : in_pc;
                d_j2    = (opc == OPC_JALR) ? imm_i : imm_j;
                bad     = (opc == OPC_JALR) && (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                d_branch = 1'b1;
                d_op1    = rdata1;
                d_op2    = rdata2;
                d_j1     = in_pc;
                d_j2     = imm_b;
                d_alu    = branch_alu_op(f3);
                bad      = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LOAD: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                d_ren   = 1'b1;
                d_op1   = rdata1;
                d_op2   = imm_i;
                d_size  = f3;
                bad     = (f3 == 3'b111) || (XLEN == 32 && (f3 == F3_LD || f3 == F3_LWU));
            end
            OPC_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                d_mwen  = 1'b1;
                d_op1   = rdata1;
                d_op2   = imm_s;
                d_sd    = rdata2;
                d_size  = f3;
                bad     = f3[2] || (XLEN == 32 && f3 == F3_SD);
            end
            OPC_OP_IMM: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                d_op1   = rdata1;
                d_op2   = imm_i;
                d_alu   = alu_from_f3(f3, (f3 == F3_SRL_SRA) && in_inst[30]);
                // shifts carry a zero-extended shamt; bit 25 is shamt[5], only meaningful on RV64
                if (f3 == F3_SLL || f3 == F3_SRL_SRA) begin
                    d_op2 = XLEN'(in_inst[25:20]);
                    bad   = in_inst[31] || (in_inst[29:26] != 4'b0) ||
                            (f3 == F3_SLL && in_inst[30]) || (XLEN == 32 && in_inst[25]);
                end
            end
            OPC_OP: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                d_op1   = rdata1;
                d_op2   = rdata2;
                d_alu   = alu_from_f3(f3, in_inst[30]);
                bad     = !((f7 == 7'h00) ||
                            (f7 == 7'h20 && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA)));
            end
            OPC_SYSTEM: begin
                d_ebreak = (in_inst == INST_EBREAK);
                bad      = (in_inst != INST_EBREAK);
            end
            default: bad = 1'b1;
        endcase
        if (RF_ADDR_W == 4)
            bad = bad || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4]) || (use_rd && rd[4]);
        d_wen   = use_rd && (rd != 5'd0);
        d_waddr = use_rd ? rd[RF_ADDR_W-1:0] : '0;
        // anything unsupported leaves the stage as a bubble-like NOP
        if (bad) begin
            d_op1    = '0;
            d_op2    = '0;
            d_j1     = '0;
            d_j2     = '0;
            d_sd     = '0;
            d_alu    = ALU_ADD;
            d_wen    = 1'b0;
            d_waddr  = '0;
            d_jump   = 1'b0;
            d_branch = 1'b0;
            d_ren    = 1'b0;
            d_mwen   = 1'b0;
            d_ebreak = 1'b0;
            d_size   = 3'b0;
        end
    end

    assign raddr1 = use_rs1 ? rs1[RF_ADDR_W-1:0] : '0;
    assign raddr2 = use_rs2 ? rs2[RF_ADDR_W-1:0] : '0;

    logic accept;
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            op1        <= '0;
            op2        <= '0;
            op1_jump   <= '0;
            op2_jump   <= '0;
            store_data <= '0;
            alu_op     <= ALU_ADD;
            reg_wen    <= 1'b0;
            waddr      <= '0;
            is_jump    <= 1'b0;
            is_branch  <= 1'b0;
            mem_ren    <= 1'b0;
            mem_wen    <= 1'b0;
            is_ebreak  <= 1'b0;
            mem_size   <= 3'b0;
            inst_o     <= INST_NOP;
            pc_o       <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            op1        <= d_op1;
            op2        <= d_op2;
            op1_jump   <= d_j1;
            op2_jump   <= d_j2;
            store_data <= d_sd;
            alu_op     <= d_alu;
            reg_wen    <= d_wen;
            waddr      <= d_waddr;
            is_jump    <= d_jump;
            is_branch  <= d_branch;
            mem_ren    <= d_ren;
            mem_wen    <= d_mwen;
            is_ebreak  <= d_ebreak;
            mem_size   <= d_size;
            inst_o     <= in_inst;
            pc_o       <= in_pc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef YSYX_23060332_IDU_ILLEGAL_CHK_EN
    always_ff @(posedge clk) begin
        if (rst)
            illegal <= 1'b0;
        else if (accept)
            illegal <= bad;
    end
`else
    assign illegal = 1'b0;
`endif

endmodule
